// File: rtl/pool_stream_unit.sv
// Pooling engine: snapshots an activation map on start, walks the output map with
// none/max/avg pooling and streams packed, saturated words over valid/ready.
module pool_stream_unit #(
    parameter int unsigned IN_H     = 8,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned IN_BITS  = 16,
    parameter int unsigned OUT_BITS = 8,
    parameter int unsigned PACK     = 4,
    parameter int unsigned MAX_K    = 3
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [1:0]                    i_pool_type,
    input  logic [2:0]                    i_pool_stride,
    input  logic [2:0]                    i_pool_kernel,
    input  logic [IN_H*IN_W*IN_BITS-1:0]  i_af_in,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_cfg_err,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [PACK*OUT_BITS-1:0]      o_out_data,
    output logic [$clog2(IN_H)-1:0]       o_out_row,
    output logic [$clog2(IN_W)-1:0]       o_out_col
);
    localparam int unsigned AF_W    = IN_H * IN_W * IN_BITS;
    localparam int unsigned AW      = $clog2(AF_W);
    localparam int unsigned RW      = $clog2(IN_H);
    localparam int unsigned CW      = $clog2(IN_W);
    localparam int unsigned SW      = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned SUM_W   = IN_BITS + $clog2(MAX_K * MAX_K) + 1;
    localparam int unsigned SAT_MAX = (32'd1 << OUT_BITS) - 32'd1;

    localparam logic [1:0] TYPE_NONE = 2'd0;
    localparam logic [1:0] TYPE_AVG  = 2'd2;
    localparam logic [1:0] TYPE_BAD  = 2'd3;

    typedef enum logic [2:0] {StIdle, StErr, StAcc, StEmit, StDone} state_t;
    state_t r_state, w_state_next;

    logic [AF_W-1:0]          r_af;
    logic [1:0]               r_type;
    logic [2:0]               r_k, r_s;
    logic [RW-1:0]            r_rs, r_or;
    logic [CW-1:0]            r_cs, r_oc, r_word_col;
    logic [2:0]               r_kr, r_kc;
    logic [SW-1:0]            r_slot;
    logic [SUM_W-1:0]         r_acc;
    logic [PACK*OUT_BITS-1:0] r_word;

    logic [2:0]          w_k_eff, w_s_eff;
    logic                w_cfg_bad;
    logic [31:0]         w_idx;
    logic [AW-1:0]       w_bit;
    logic [IN_BITS-1:0]  w_elem;
    logic [SUM_W-1:0]    w_fold, w_kk, w_res;
    logic [OUT_BITS-1:0] w_sat;
    logic                w_win_last, w_last_col, w_last_row, w_slot_full, w_word_end;

    // NONE ignores the kernel/stride ports and is always a 1x1, stride-1 walk.
    always_comb begin
        w_k_eff   = (i_pool_type == TYPE_NONE) ? 3'd1 : i_pool_kernel;
        w_s_eff   = (i_pool_type == TYPE_NONE) ? 3'd1 : i_pool_stride;
        w_cfg_bad = (i_pool_type == TYPE_BAD) || (w_k_eff == 3'd0) || (w_s_eff == 3'd0) ||
                    (32'(w_k_eff) > MAX_K) || (32'(w_k_eff) > IN_H) || (32'(w_k_eff) > IN_W);
    end

    always_comb begin
        w_idx  = (32'(r_rs) + 32'(r_kr)) * IN_W + 32'(r_cs) + 32'(r_kc);
        w_bit  = AW'(w_idx * IN_BITS);
        w_elem = r_af[w_bit +: IN_BITS];
        if (r_type == TYPE_AVG) begin
            w_fold = r_acc + SUM_W'(w_elem);
        end else begin
            w_fold = (SUM_W'(w_elem) > r_acc) ? SUM_W'(w_elem) : r_acc;
        end
        w_kk  = SUM_W'(r_k) * SUM_W'(r_k);
        w_res = (r_type == TYPE_AVG) ? (w_fold / w_kk) : w_fold;
        w_sat = (w_res > SUM_W'(SAT_MAX)) ? '1 : w_res[OUT_BITS-1:0];
    end

    // A window is last in its row/column when the next stride step would not fit.
    always_comb begin
        w_win_last  = (r_kr == r_k - 3'd1) && (r_kc == r_k - 3'd1);
        w_last_col  = (32'(r_cs) + 32'(r_s) + 32'(r_k)) > IN_W;
        w_last_row  = (32'(r_rs) + 32'(r_s) + 32'(r_k)) > IN_H;
        w_slot_full = (r_slot == SW'(PACK - 1));
        w_word_end  = w_slot_full || w_last_col;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (i_start) w_state_next = w_cfg_bad ? StErr : StAcc;
            StErr:  w_state_next = StIdle;
            StAcc:  if (w_win_last && w_word_end) w_state_next = StEmit;
            StEmit: if (i_out_ready) w_state_next = (w_last_col && w_last_row) ? StDone : StAcc;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_af       <= '0;
            r_type     <= '0;
            r_k        <= '0;
            r_s        <= '0;
            r_rs       <= '0;
            r_or       <= '0;
            r_cs       <= '0;
            r_oc       <= '0;
            r_word_col <= '0;
            r_kr       <= '0;
            r_kc       <= '0;
            r_slot     <= '0;
            r_acc      <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_af   <= i_af_in;
                        r_type <= i_pool_type;
                        r_k    <= w_k_eff;
                        r_s    <= w_s_eff;
                        r_rs   <= '0;
                        r_or   <= '0;
                        r_cs   <= '0;
                        r_oc   <= '0;
                        r_kr   <= '0;
                        r_kc   <= '0;
                        r_slot <= '0;
                        r_acc  <= '0;
                        r_word <= '0;
                    end
                end
                StAcc: begin
                    if (w_win_last) begin
                        r_acc <= '0;
                        r_kr  <= '0;
                        r_kc  <= '0;
                        for (int i = 0; i < PACK; i++) begin
                            if (r_slot == SW'(i)) r_word[i*OUT_BITS +: OUT_BITS] <= w_sat;
                        end
                        if (r_slot == '0) r_word_col <= r_oc;
                        if (!w_word_end) begin
                            r_cs   <= r_cs + CW'(r_s);
                            r_oc   <= r_oc + CW'(1);
                            r_slot <= r_slot + SW'(1);
                        end
                    end else begin
                        r_acc <= w_fold;
                        if (r_kc == r_k - 3'd1) begin
                            r_kc <= '0;
                            r_kr <= r_kr + 3'd1;
                        end else begin
                            r_kc <= r_kc + 3'd1;
                        end
                    end
                end
                StEmit: begin
                    if (i_out_ready) begin
                        r_word <= '0;
                        r_slot <= '0;
                        if (w_last_col) begin
                            if (!w_last_row) begin
                                r_rs <= r_rs + RW'(r_s);
                                r_or <= r_or + RW'(1);
                                r_cs <= '0;
                                r_oc <= '0;
                            end
                        end else begin
                            r_cs <= r_cs + CW'(r_s);
                            r_oc <= r_oc + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy      = (r_state == StAcc) || (r_state == StEmit);
        o_done      = (r_state == StDone) || (r_state == StErr);
        o_cfg_err   = (r_state == StErr);
        o_out_valid = (r_state == StEmit);
        o_out_data  = o_out_valid ? r_word : '0;
        o_out_row   = o_out_valid ? r_or : '0;
        o_out_col   = o_out_valid ? r_word_col : '0;
    end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Self-checking bench for pool_stream_unit on a 4x4 map: vector table, scoreboard
// queue of expected words, plus stall, illegal-config and mid-job reset sequences.
module tb_pool_stream_unit;
    localparam int H   = 4;
    localparam int W   = 4;
    localparam int IB  = 16;
    localparam int OB  = 8;
    localparam int P   = 4;
    localparam int MK  = 3;
    localparam int AFW = H * W * IB;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         ptype;
    logic [2:0]         pstride, pkernel;
    logic [AFW-1:0]     af;
    logic               busy, done, cfg_err, out_valid, out_ready;
    logic [P*OB-1:0]    out_data;
    logic [1:0]         out_row, out_col;

    pool_stream_unit #(
        .IN_H(H), .IN_W(W), .IN_BITS(IB), .OUT_BITS(OB), .PACK(P), .MAX_K(MK)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_pool_type  (ptype),
        .i_pool_stride(pstride),
        .i_pool_kernel(pkernel),
        .i_af_in      (af),
        .o_busy       (busy),
        .o_done       (done),
        .o_cfg_err    (cfg_err),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_row    (out_row),
        .o_out_col    (out_col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
    } exp_t;

    typedef struct {
        logic [1:0]       ty;
        logic [2:0]       k;
        logic [2:0]       s;
        int               fill;
        int               nwords;
        int               lat;
        logic [3:0][31:0] words;
    } vec_t;

    exp_t q[$];
    exp_t e_mon;
    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   words_seen = 0;
    int   last_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            words_seen++;
            last_hs_cyc = cyc;
            check("word_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e_mon = q.pop_front();
                check("word_data", 64'(out_data), 64'(e_mon.data));
                check("word_row", 64'(out_row), 64'(e_mon.row));
                check("word_col", 64'(out_col), 64'(e_mon.col));
            end
        end
    end

    task automatic set_af(input int fill);
        af = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                af = af | (AFW'((fill < 0) ? (4 * r + c) : fill) << ((r * W + c) * IB));
            end
        end
    endtask

    // Drives one job from the table and checks latency, busy, words and done timing.
    task automatic run_vec(input int i);
        int n;
        int m;
        exp_t e;
        ptype   = vecs[i].ty;
        pkernel = vecs[i].k;
        pstride = vecs[i].s;
        set_af(vecs[i].fill);
        out_ready = 1'b1;
        for (int w = 0; w < vecs[i].nwords; w++) begin
            e.data = vecs[i].words[w];
            e.row  = 2'(w);
            e.col  = 2'd0;
            q.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        ptype   = 2'd3;
        pkernel = 3'd0;
        pstride = 3'd0;
        af      = '1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_after_start", 64'(busy), 64'd1);
                check("no_cfg_err_legal", 64'(cfg_err), 64'd0);
            end
            if (out_valid) break;
        end
        check("first_word_latency", 64'(n), 64'(vecs[i].lat));
        m = 0;
        while (!done && m < 500) begin
            @(negedge clk);
            m++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("done_after_last_hs", 64'(cyc - last_hs_cyc), 64'd1);
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("words_left", 64'(q.size()), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_low_after", 64'(busy), 64'd0);
        q.delete();
    endtask

    logic [1:0] bad_ty[5];
    logic [2:0] bad_k[5];
    logic [2:0] bad_s[5];

    initial begin
        int n;
        int ws0;
        logic seen;
        exp_t e;

        vecs[0] = '{ty: 2'd0, k: 3'd7, s: 3'd0, fill: -1, nwords: 4, lat: 5,
                    words: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}};
        vecs[1] = '{ty: 2'd1, k: 3'd2, s: 3'd2, fill: -1, nwords: 2, lat: 9,
                    words: {32'h0, 32'h0, 32'h00000F0D, 32'h00000705}};
        vecs[2] = '{ty: 2'd2, k: 3'd2, s: 3'd2, fill: -1, nwords: 2, lat: 9,
                    words: {32'h0, 32'h0, 32'h00000C0A, 32'h00000402}};
        vecs[3] = '{ty: 2'd1, k: 3'd3, s: 3'd1, fill: 300, nwords: 2, lat: 19,
                    words: {32'h0, 32'h0, 32'h0000FFFF, 32'h0000FFFF}};
        vecs[4] = '{ty: 2'd2, k: 3'd3, s: 3'd1, fill: -1, nwords: 2, lat: 19,
                    words: {32'h0, 32'h0, 32'h00000A09, 32'h00000605}};
        vecs[5] = '{ty: 2'd1, k: 3'd1, s: 3'd2, fill: -1, nwords: 2, lat: 3,
                    words: {32'h0, 32'h0, 32'h00000A08, 32'h00000200}};
        vecs[6] = '{ty: 2'd1, k: 3'd2, s: 3'd1, fill: -1, nwords: 3, lat: 13,
                    words: {32'h0, 32'h000F0E0D, 32'h000B0A09, 32'h00070605}};
        vecs[7] = '{ty: 2'd2, k: 3'd2, s: 3'd2, fill: 300, nwords: 2, lat: 9,
                    words: {32'h0, 32'h0, 32'h0000FFFF, 32'h0000FFFF}};

        bad_ty = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd2};
        bad_k  = '{3'd5, 3'd1, 3'd0, 3'd2, 3'd4};
        bad_s  = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd1};

        rst = 1'b1;
        start = 1'b0;
        ptype = 2'd0;
        pkernel = 3'd1;
        pstride = 3'd1;
        out_ready = 1'b1;
        set_af(-1);
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Back-pressure on the first word, with start pulses that must be ignored.
        ptype = 2'd0;
        pkernel = 3'd1;
        pstride = 3'd1;
        set_af(-1);
        out_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            e.data = vecs[0].words[w];
            e.row  = 2'(w);
            e.col  = 2'd0;
            q.push_back(e);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        ptype = 2'd1;
        pkernel = 3'd2;
        pstride = 3'd2;
        set_af(300);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_first_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = (c == 2);
            @(negedge clk);
            check("stall_valid_held", 64'(out_valid), 64'd1);
            check("stall_data_stable", 64'(out_data), 64'h03020100);
        end
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_done_seen", 64'(done), 64'd1);
        check("stall_words_left", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("stall_no_restart", 64'(busy), 64'd0);
        q.delete();

        // Illegal configurations: cfg_err and done pulse together, no words.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ptype = bad_ty[i];
            pkernel = bad_k[i];
            pstride = bad_s[i];
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("bad_cfg_err", 64'(cfg_err), 64'd1);
            check("bad_done", 64'(done), 64'd1);
            check("bad_no_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            check("bad_cfg_err_pulse", 64'(cfg_err), 64'd0);
            check("bad_done_pulse", 64'(done), 64'd0);
        end

        // Reset while accumulating row 1 abandons the job.
        @(posedge clk); #1;
        ptype = 2'd0;
        set_af(-1);
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            e.data = vecs[0].words[w];
            e.row  = 2'(w);
            e.col  = 2'd0;
            q.push_back(e);
        end
        ws0 = words_seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (words_seen == ws0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_first_word", 64'(words_seen - ws0), 64'd1);
        @(negedge clk);
        check("reset_test_in_acc", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_data", 64'(out_data), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || out_valid) seen = 1'b1;
        end
        check("no_done_after_reset", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run_vec(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pool_stream_unit.md
Name: pool_stream_unit

Overview:
Parametrised pooling engine between the activation-function array and the output SRAM. On start it snapshots the full activation map, then walks the output map sequentially, computing none/max/average pooling with runtime kernel size and stride. It emits packed, saturated SRAM words over a valid/ready handshake.

Parameters:
IN_H, 8, activation map rows
IN_W, 8, activation map columns
IN_BITS, 16, activation element width (unsigned)
OUT_BITS, 8, stored element width
PACK, 4, elements per SRAM word
MAX_K, 3, largest legal kernel size

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
pool_type  in  2  0 NONE, 1 MAX, 2 AVG, 3 illegal
pool_stride  in  3  stride S
pool_kernel  in  3  kernel size K
af_in  in  IN_H*IN_W*IN_BITS  activation map, element (r,c) at bit offset (r*IN_W+c)*IN_BITS
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at job end
cfg_err  out  1  one-cycle pulse on illegal configuration
out_valid  out  1  word available
out_ready  in  1  consumer accepts word
out_data  out  PACK*OUT_BITS  packed word, slot i at bits [i*OUT_BITS +: OUT_BITS]
out_row  out  clog2(IN_H)  output row of word
out_col  out  clog2(IN_W)  output column of slot 0

Behaviour:
- Reset (async): all outputs 0, FSM to IDLE, counters and accumulators cleared. Reset mid-job abandons the job; no partial word or done.
- On start in IDLE: latch af_in, type, K, S into internal registers. Upstream may change its inputs afterwards. start while busy is ignored.
- NONE forces K=1, S=1 regardless of the ports.
- Illegal configuration: type 3; K=0; S=0; K>MAX_K; K>IN_H; or K>IN_W.
  - Next cycle: cfg_err=1 and done=1 for one cycle; no words emitted; return to IDLE.
- Output dimensions: OH=(IN_H-K)/S+1, OW=(IN_W-K)/S+1, integer floor.
- States:
  - IDLE -> ACC on legal start.
  - ACC: one window element per cycle, kr then kc row-major; K*K cycles per output element. Result goes to slot (oc mod PACK).
  - ACC -> EMIT when PACK slots are filled or oc=OW-1; otherwise next element.
  - EMIT: out_valid=1; out_data/out_row/out_col stable until out_ready.
  - On handshake: -> ACC for the next element, or -> DONE after the last word.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- Packing:
  - Words never span output rows.
  - Unused slots in a row's last word are 0.
  - Each row yields ceil(OW/PACK) words.
- Arithmetic:
  - MAX is an unsigned compare, initial value 0.
  - AVG sum width is IN_BITS+clog2(MAX_K*MAX_K)+1, divided by K*K with truncation.
  - The result then saturates to OUT_BITS: any value > 2^OUT_BITS-1 becomes all ones.
- out_valid is registered. A word is presented the cycle after its last element completes.
- Words emitted in order: row 0 first, ascending column within a row.

Test Plan:
(IN_H=IN_W=4, PACK=4, OUT_BITS=8, IN_BITS=16; af(r,c)=4r+c unless stated.)
1. NONE, out_ready=1 -> exactly 4 words:
   - row0 out_data=0x03020100, out_col=0; row3=0x0F0E0D0C.
   - done one cycle after the last handshake; busy low afterwards.
2. MAX K=2 S=2 -> 2 words: row0=0x00000705, row1=0x00000F0D; each element takes 4 ACC cycles.
3. AVG K=2 S=2 -> row0=0x00000402 (10/4=2, 18/4=4), row1=0x00000C0A.
4. All af=300, MAX K=3 S=1 -> OH=OW=2, words 0x0000FFFF (saturation) on rows 0 and 1.
5. NONE with out_ready low 5 cycles at the first word:
   - out_valid held, out_data stable at 0x03020100.
   - No word lost or duplicated; start pulsed mid-job is ignored.
6. Illegal configurations and reset:
   - K=5 -> cfg_err and done pulse together, no out_valid.
   - Reset asserted during ACC of row 1 -> outputs 0 immediately, no done; a fresh start completes normally.
